// File: rtl/xood_seq_pkg.sv
// Shared types and constants for the Xoodyak test-vector sequencer.
// Defining XOOD_SEQ_ROUNDTRIP_EN adds the decrypt-leg states to the state enum.
package xood_seq_pkg;

  localparam int FIELD_W    = 128;
  // Record text fields are sized for the largest supported TEXT_W.
  localparam int MAX_TEXT_W = 192;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ISSUE_ENC,
    S_WAIT_ENC,
    S_CHECK_ENC,
`ifdef XOOD_SEQ_ROUNDTRIP_EN
    S_ISSUE_DEC,
    S_WAIT_DEC,
    S_CHECK_DEC,
`endif
    S_NEXT,
    S_DONE
  } seq_state_t;

  typedef struct packed {
    logic [FIELD_W-1:0]    key;
    logic [FIELD_W-1:0]    nonce;
    logic [FIELD_W-1:0]    ad;
    logic [MAX_TEXT_W-1:0] pt;
    logic [MAX_TEXT_W-1:0] ct;
    logic [FIELD_W-1:0]    tag;
  } xood_vec_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/xood_timeout_ctr.sv
// Down-counting wait timer shared by the sequencer WAIT states.
// o_expired is high once the loaded count has run down to zero.
module xood_timeout_ctr #(
  parameter int CNT_W = 10
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_load_val;
    else if (i_en && (r_cnt != '0))
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/xood_vector_seq.sv
// Replays stored known-answer vectors through a Xoodyak core and tallies pass/fail.
// XOOD_SEQ_ROUNDTRIP_EN adds a decrypt leg that feeds the captured ciphertext back.
//
// state     | meaning
// IDLE      | table writable, waiting for run
// ISSUE_ENC | load core inputs from current vector, pulse core_start
// WAIT_ENC  | wait for core_done or timeout
// CHECK_ENC | compare captured tag/ciphertext
// ISSUE_DEC | (roundtrip) replay captured ciphertext with opmode=1
// WAIT_DEC  | (roundtrip) wait for core_done or timeout
// CHECK_DEC | (roundtrip) compare recovered plaintext/tag, record result
// NEXT      | advance index or finish
// DONE      | seq_done pulse, return to IDLE
module xood_vector_seq
  import xood_seq_pkg::*;
#(
  parameter int NUM_VEC     = 4,
  parameter int TEXT_W      = 192,
  parameter int TIMEOUT_CYC = 1024,
  localparam int IDX_W      = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
  input  logic               eph1,
  input  logic               reset_n,
  input  logic               run,
  input  logic               vec_we,
  input  logic [IDX_W-1:0]   vec_idx,
  input  logic [127:0]       vec_key,
  input  logic [127:0]       vec_nonce,
  input  logic [127:0]       vec_ad,
  input  logic [127:0]       vec_tag,
  input  logic [TEXT_W-1:0]  vec_pt,
  input  logic [TEXT_W-1:0]  vec_ct,
  output logic               core_start,
  output logic [127:0]       core_key,
  output logic [127:0]       core_nonce,
  output logic [127:0]       core_assodata,
  output logic [TEXT_W-1:0]  core_textin,
  output logic               core_opmode,
  input  logic [127:0]       core_authdata,
  input  logic [TEXT_W-1:0]  core_textout,
  input  logic               core_done,
  output logic               busy,
  output logic               seq_done,
  output logic [15:0]        pass_cnt,
  output logic [15:0]        fail_cnt,
  output logic [IDX_W-1:0]   first_fail_idx,
  output logic               fail_seen
);

  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  seq_state_t         r_state;
  xood_vec_t          r_table [NUM_VEC];
  logic [IDX_W-1:0]   r_idx;
  logic [FIELD_W-1:0] r_cap_tag;
  logic [TEXT_W-1:0]  r_cap_text;
  logic               r_timeout;
  xood_vec_t          w_vec;
  logic               w_tag_ok, w_ct_ok, w_record, w_record_ok;
  logic               w_tmr_load, w_tmr_en, w_expired;

  // Table is not reset; contents are undefined after reset.
  always_ff @(posedge eph1) begin
    if (vec_we && !busy)
      r_table[vec_idx] <= '{key: vec_key, nonce: vec_nonce, ad: vec_ad,
                            pt: MAX_TEXT_W'(vec_pt), ct: MAX_TEXT_W'(vec_ct),
                            tag: vec_tag};
  end

  assign w_vec    = r_table[r_idx];
  assign w_tag_ok = (r_cap_tag == w_vec.tag);
  assign w_ct_ok  = (MAX_TEXT_W'(r_cap_text) == w_vec.ct);

`ifdef XOOD_SEQ_ROUNDTRIP_EN
  logic r_enc_ok;
  logic w_pt_ok;
  assign w_pt_ok     = (MAX_TEXT_W'(r_cap_text) == w_vec.pt);
  // An encrypt timeout has no ciphertext to replay, so it is recorded immediately.
  assign w_record    = (r_state == S_CHECK_DEC) || ((r_state == S_CHECK_ENC) && r_timeout);
  assign w_record_ok = (r_state == S_CHECK_DEC) && r_enc_ok && !r_timeout && w_tag_ok && w_pt_ok;
  assign w_tmr_load  = (r_state == S_ISSUE_ENC) || (r_state == S_ISSUE_DEC);
  assign w_tmr_en    = (r_state == S_WAIT_ENC) || (r_state == S_WAIT_DEC);
`else
  assign w_record    = (r_state == S_CHECK_ENC);
  assign w_record_ok = !r_timeout && w_tag_ok && w_ct_ok;
  assign w_tmr_load  = (r_state == S_ISSUE_ENC);
  assign w_tmr_en    = (r_state == S_WAIT_ENC);
`endif

  xood_timeout_ctr #(.CNT_W(TMR_W)) u_timeout (
    .clk_sys    (eph1),
    .rst_n      (reset_n),
    .i_load     (w_tmr_load),
    .i_load_val (TMR_W'(TIMEOUT_CYC - 1)),
    .i_en       (w_tmr_en),
    .o_expired  (w_expired)
  );

  always_ff @(posedge eph1 or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_idx          <= '0;
      r_cap_tag      <= '0;
      r_cap_text     <= '0;
      r_timeout      <= 1'b0;
`ifdef XOOD_SEQ_ROUNDTRIP_EN
      r_enc_ok       <= 1'b0;
`endif
      core_start     <= 1'b0;
      core_key       <= '0;
      core_nonce     <= '0;
      core_assodata  <= '0;
      core_textin    <= '0;
      core_opmode    <= 1'b0;
      busy           <= 1'b0;
      seq_done       <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '0;
      fail_seen      <= 1'b0;
    end else begin
      core_start <= 1'b0;
      seq_done   <= 1'b0;
      if (w_record) begin
        if (w_record_ok) begin
          pass_cnt <= sat_inc(pass_cnt);
        end else begin
          fail_cnt <= sat_inc(fail_cnt);
          if (!fail_seen) begin
            fail_seen      <= 1'b1;
            first_fail_idx <= r_idx;
          end
        end
      end
      case (r_state)
        S_IDLE: begin
          if (run) begin
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            fail_seen      <= 1'b0;
            first_fail_idx <= '0;
            r_idx          <= '0;
            busy           <= 1'b1;
            r_state        <= S_ISSUE_ENC;
          end
        end
        S_ISSUE_ENC: begin
          core_key      <= w_vec.key;
          core_nonce    <= w_vec.nonce;
          core_assodata <= w_vec.ad;
          core_textin   <= w_vec.pt[TEXT_W-1:0];
          core_opmode   <= 1'b0;
          core_start    <= 1'b1;
          r_state       <= S_WAIT_ENC;
        end
        S_WAIT_ENC: begin
          if (core_done) begin
            r_cap_tag  <= core_authdata;
            r_cap_text <= core_textout;
            r_timeout  <= 1'b0;
            r_state    <= S_CHECK_ENC;
          end else if (w_expired) begin
            r_timeout <= 1'b1;
            r_state   <= S_CHECK_ENC;
          end
        end
`ifdef XOOD_SEQ_ROUNDTRIP_EN
        S_CHECK_ENC: begin
          if (r_timeout) begin
            r_state <= S_NEXT;
          end else begin
            r_enc_ok <= w_tag_ok && w_ct_ok;
            r_state  <= S_ISSUE_DEC;
          end
        end
        S_ISSUE_DEC: begin
          core_textin <= r_cap_text;
          core_opmode <= 1'b1;
          core_start  <= 1'b1;
          r_state     <= S_WAIT_DEC;
        end
        S_WAIT_DEC: begin
          if (core_done) begin
            r_cap_tag  <= core_authdata;
            r_cap_text <= core_textout;
            r_timeout  <= 1'b0;
            r_state    <= S_CHECK_DEC;
          end else if (w_expired) begin
            r_timeout <= 1'b1;
            r_state   <= S_CHECK_DEC;
          end
        end
        S_CHECK_DEC: r_state <= S_NEXT;
`else
        S_CHECK_ENC: r_state <= S_NEXT;
`endif
        S_NEXT: begin
          if (r_idx == IDX_W'(NUM_VEC - 1)) begin
            seq_done <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= S_ISSUE_ENC;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xood_vector_seq.sv
// Directed bench for xood_vector_seq with a toy XOR "core" standing in for Xoodyak.
// Build with XOOD_SEQ_ROUNDTRIP_EN to exercise the decrypt leg as well.
module tb_xood_vector_seq;

  localparam int NV = 4;
  localparam int TW = 192;
  localparam int TO = 16;
`ifdef XOOD_SEQ_ROUNDTRIP_EN
  localparam int LEGS = 2;
`else
  localparam int LEGS = 1;
`endif

  logic          eph1 = 1'b0;
  logic          reset_n = 1'b0;
  logic          run = 1'b0;
  logic          vec_we = 1'b0;
  logic [1:0]    vec_idx = '0;
  logic [127:0]  vec_key = '0, vec_nonce = '0, vec_ad = '0, vec_tag = '0;
  logic [TW-1:0] vec_pt = '0, vec_ct = '0;
  logic          core_start, core_opmode, core_done;
  logic [127:0]  core_key, core_nonce, core_assodata, core_authdata;
  logic [TW-1:0] core_textin, core_textout;
  logic          busy, seq_done, fail_seen;
  logic [15:0]   pass_cnt, fail_cnt;
  logic [1:0]    first_fail_idx;

  int checks = 0;
  int errors = 0;

  always #5 eph1 = ~eph1;

  xood_vector_seq #(.NUM_VEC(NV), .TEXT_W(TW), .TIMEOUT_CYC(TO)) dut (
    .eph1(eph1), .reset_n(reset_n), .run(run), .vec_we(vec_we), .vec_idx(vec_idx),
    .vec_key(vec_key), .vec_nonce(vec_nonce), .vec_ad(vec_ad), .vec_tag(vec_tag),
    .vec_pt(vec_pt), .vec_ct(vec_ct),
    .core_start(core_start), .core_key(core_key), .core_nonce(core_nonce),
    .core_assodata(core_assodata), .core_textin(core_textin), .core_opmode(core_opmode),
    .core_authdata(core_authdata), .core_textout(core_textout), .core_done(core_done),
    .busy(busy), .seq_done(seq_done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .first_fail_idx(first_fail_idx), .fail_seen(fail_seen)
  );

  // Toy core: text ^= {nonce[63:0], key}, tag = key ^ nonce ^ ad; done a few cycles later.
  logic         m_hang_en = 1'b0;
  logic [127:0] m_hang_key = '0;
  int           m_cnt;
  always @(posedge eph1 or negedge reset_n) begin
    if (!reset_n) begin
      core_done     <= 1'b0;
      core_authdata <= '0;
      core_textout  <= '0;
      m_cnt         <= -1;
    end else begin
      core_done <= 1'b0;
      if (core_start) begin
        core_textout  <= core_textin ^ {core_nonce[63:0], core_key};
        core_authdata <= core_key ^ core_nonce ^ core_assodata;
        m_cnt         <= (m_hang_en && (core_key == m_hang_key)) ? -1 : 2;
      end else if (m_cnt == 0) begin
        core_done <= 1'b1;
        m_cnt     <= -1;
      end else if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  logic [127:0]  t_key [NV], t_nonce [NV], t_ad [NV], t_tag [NV];
  logic [TW-1:0] t_pt [NV], t_ct [NV];
  int            starts, pulses, cyc_start, cyc_fail, bad_op, n;
  logic [127:0]  first_key;
  logic [7:0]    bi;

  task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_vec(input int i, input logic [127:0] tag_x);
    vec_we    = 1'b1;
    vec_idx   = 2'(i);
    vec_key   = t_key[i];
    vec_nonce = t_nonce[i];
    vec_ad    = t_ad[i];
    vec_pt    = t_pt[i];
    vec_ct    = t_ct[i];
    vec_tag   = t_tag[i] ^ tag_x;
    @(negedge eph1);
    vec_we = 1'b0;
  endtask

  // mode 0: plain run; 1: run/vec_we pulsed while busy; 2: vector 0 rewritten (bad tag) with run.
  task automatic run_seq(input int mode);
    int  c;
    bit  fin;
    c = 0; fin = 0;
    starts = 0; pulses = 0; cyc_start = -1; cyc_fail = -1; bad_op = 0; first_key = '0;
    if (mode == 2) begin
      vec_we = 1'b1; vec_idx = 2'd0; vec_key = t_key[0]; vec_nonce = t_nonce[0];
      vec_ad = t_ad[0]; vec_pt = t_pt[0]; vec_ct = t_ct[0]; vec_tag = t_tag[0] ^ 128'h8;
    end
    run = 1'b1;
    @(negedge eph1);
    run = 1'b0; vec_we = 1'b0;
    while (!fin && c < 3000) begin
      if (core_start) begin
        if (starts == 0) first_key = core_key;
        if (starts == LEGS) cyc_start = c;
        if (core_opmode !== ((LEGS == 2) && (starts % 2 == 1))) bad_op++;
        starts++;
      end
      if (seq_done) pulses++;
      if (fail_cnt != 16'd0 && cyc_fail < 0) cyc_fail = c;
      if (mode == 1 && c == 4) begin
        run = 1'b1; vec_we = 1'b1; vec_idx = 2'd3; vec_tag = ~t_tag[3];
      end else if (mode == 1 && c == 5) begin
        run = 1'b0; vec_we = 1'b0;
      end
      if (!busy) fin = 1;
      @(negedge eph1);
      c++;
    end
    chk("run_terminates", TW'(fin), TW'(1));
    repeat (4) begin
      if (seq_done) pulses++;
      @(negedge eph1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int b = 0; b < 16; b++) begin
      t_key[0][127-8*b -: 8]   = 8'h61 + 8'(b);
      t_nonce[0][127-8*b -: 8] = 8'h30 + 8'(b);
      t_ad[0][127-8*b -: 8]    = 8'h41 + 8'(b);
    end
    for (int b = 0; b < 24; b++) t_pt[0][TW-1-8*b -: 8] = 8'h41 + 8'(b);
    for (int i = 0; i < NV; i++) begin
      bi = 8'(i * 17);
      if (i > 0) begin
        t_key[i]   = t_key[0] ^ {16{bi}};
        t_nonce[i] = t_nonce[0] + 128'(i);
        t_ad[i]    = ~t_ad[0] ^ {16{bi}};
        t_pt[i]    = t_pt[0] ^ {24{bi}};
      end
      t_ct[i]  = t_pt[i] ^ {t_nonce[i][63:0], t_key[i]};
      t_tag[i] = t_key[i] ^ t_nonce[i] ^ t_ad[i];
    end

    // Reset state
    repeat (3) @(negedge eph1);
    chk("rst_busy", TW'(busy), TW'(0));
    chk("rst_pass", TW'(pass_cnt), TW'(0));
    chk("rst_fail_seen", TW'(fail_seen), TW'(0));
    chk("rst_core_start", TW'(core_start), TW'(0));
    chk("rst_core_key", TW'(core_key), TW'(0));
    reset_n = 1'b1;
    @(negedge eph1);

    for (int i = 0; i < NV; i++) write_vec(i, '0);

    // All vectors correct
    run_seq(0);
    chk("all_pass_cnt", TW'(pass_cnt), TW'(4));
    chk("all_fail_cnt", TW'(fail_cnt), TW'(0));
    chk("all_fail_seen", TW'(fail_seen), TW'(0));
    chk("all_seq_done_pulses", TW'(pulses), TW'(1));
    chk("all_starts", TW'(starts), TW'(NV * LEGS));
    chk("all_opmode", TW'(bad_op), TW'(0));
    chk("all_first_key", TW'(first_key), TW'(t_key[0]));
    chk("all_textin_last", core_textin, (LEGS == 2) ? t_ct[3] : t_pt[3]);

    // Vector 2 tag bit 0 flipped
    write_vec(2, 128'h1);
    run_seq(0);
    chk("tag2_pass", TW'(pass_cnt), TW'(3));
    chk("tag2_fail", TW'(fail_cnt), TW'(1));
    chk("tag2_first_idx", TW'(first_fail_idx), TW'(2));
    chk("tag2_fail_seen", TW'(fail_seen), TW'(1));
    write_vec(2, '0);

    // Two failures: first index is kept
    write_vec(1, 128'h1);
    write_vec(3, 128'h2);
    run_seq(0);
    chk("two_pass", TW'(pass_cnt), TW'(2));
    chk("two_fail", TW'(fail_cnt), TW'(2));
    chk("two_first_idx", TW'(first_fail_idx), TW'(1));
    write_vec(1, '0);
    write_vec(3, '0);

    // Write and run in the same IDLE cycle
    run_seq(2);
    chk("wrrun_pass", TW'(pass_cnt), TW'(3));
    chk("wrrun_fail", TW'(fail_cnt), TW'(1));
    chk("wrrun_first_idx", TW'(first_fail_idx), TW'(0));
    write_vec(0, '0);

    // Core never answers vector 1
    m_hang_en = 1'b1; m_hang_key = t_key[1];
    run_seq(0);
    m_hang_en = 1'b0;
    chk("to_fail", TW'(fail_cnt), TW'(1));
    chk("to_pass", TW'(pass_cnt), TW'(3));
    chk("to_first_idx", TW'(first_fail_idx), TW'(1));
    chk("to_latency", TW'(cyc_fail - cyc_start), TW'(17));

    // run and vec_we while busy
    run_seq(1);
    chk("busy_starts", TW'(starts), TW'(NV * LEGS));
    chk("busy_pass", TW'(pass_cnt), TW'(4));
    run_seq(0);
    chk("busy_table_intact", TW'(pass_cnt), TW'(4));

    // Reset during WAIT_ENC of vector 1
    run = 1'b1;
    @(negedge eph1);
    run = 1'b0;
    n = 0; starts = 0;
    while (starts < LEGS + 1 && n < 500) begin
      if (core_start) starts++;
      @(negedge eph1);
      n++;
    end
    chk("mid_reached_vec1", TW'(starts), TW'(LEGS + 1));
    chk("mid_pass_before", TW'(pass_cnt), TW'(1));
    chk("mid_busy_before", TW'(busy), TW'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", TW'(busy), TW'(0));
    chk("mid_rst_pass", TW'(pass_cnt), TW'(0));
    chk("mid_rst_core_key", TW'(core_key), TW'(0));
    chk("mid_rst_textin", core_textin, TW'(0));
    chk("mid_rst_opmode", TW'(core_opmode), TW'(0));
    repeat (2) @(negedge eph1);
    reset_n = 1'b1;
    @(negedge eph1);
    chk("mid_idle_after", TW'(busy), TW'(0));
    for (int i = 0; i < NV; i++) write_vec(i, '0);
    run_seq(0);
    chk("restart_first_key", TW'(first_key), TW'(t_key[0]));
    chk("restart_pass", TW'(pass_cnt), TW'(4));
    chk("restart_fail", TW'(fail_cnt), TW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xood_vector_seq.md
XOOD_VECTOR_SEQ -- requirements
Module: xood_vector_seq

Interface
REQ-001 SHALL have parameter NUM_VEC, default 4, meaning the number of stored test vectors (at least 1).
REQ-002 SHALL have parameter TEXT_W, default 192, meaning the plaintext and ciphertext width in bits.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024, meaning the maximum cycles to wait for core_done.
REQ-004 SHALL have port eph1, input, 1 bit: clock; a single clock domain is used.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port run, input, 1 bit: start the sequence; sampled only in IDLE.
REQ-007 SHALL have port vec_we, input, 1 bit: write enable for the vector table.
REQ-008 SHALL have port vec_idx, input, $clog2(NUM_VEC) bits: vector table write index.
REQ-009 SHALL have ports vec_key, vec_nonce, vec_ad, vec_tag, input, 128 bits each: key, nonce, associated data and expected tag.
REQ-010 SHALL have ports vec_pt and vec_ct, input, TEXT_W bits each: plaintext and expected ciphertext.
REQ-011 SHALL have port core_start, output, 1 bit: one-cycle start pulse to the Xoodyak core.
REQ-012 SHALL have ports core_key, core_nonce, core_assodata (output, 128 bits each), core_textin (output, TEXT_W bits) and core_opmode (output, 1 bit; 0 = encrypt, 1 = decrypt).
REQ-013 SHALL have ports core_authdata (input, 128 bits), core_textout (input, TEXT_W bits) and core_done (input, 1 bit).
REQ-014 SHALL have ports busy (output, 1), seq_done (output, 1), pass_cnt (output, 16), fail_cnt (output, 16), first_fail_idx (output, $clog2(NUM_VEC)) and fail_seen (output, 1).

Function
REQ-015 SHALL implement the FSM IDLE -> ISSUE_ENC -> WAIT_ENC -> CHECK_ENC -> NEXT, then back to ISSUE_ENC or on to DONE, with DONE -> IDLE.
REQ-016 SHALL, in IDLE with run=1, clear the counters, fail_seen and first_fail_idx, set the vector index to 0 and enter ISSUE_ENC on the next edge.
REQ-017 SHALL, in ISSUE_ENC, drive all core_* data outputs from the current vector, assert core_start for exactly one cycle, and enter WAIT_ENC; the core_* data outputs SHALL stay stable until the matching CHECK state.
REQ-018 SHALL, in WAIT_ENC, capture core_authdata and core_textout on the cycle core_done=1; the check SHALL happen in the following cycle (CHECK_ENC), giving 1-cycle latency from done.
REQ-019 SHALL mark a vector as passing only if captured tag == vec_tag and captured text == vec_ct.
REQ-020 SHALL, for each vector, increment pass_cnt or fail_cnt by exactly 1, and both counters SHALL saturate at 16'hFFFF.
REQ-021 SHALL, on the first failure, set fail_seen and latch the vector index into first_fail_idx; later failures SHALL NOT overwrite it.
REQ-022 SHALL count a wait exceeding TIMEOUT_CYC cycles as a failure and proceed to NEXT; a core_done that arrives late SHALL be ignored outside WAIT states.
REQ-023 SHALL, in NEXT, move to DONE when the index equals NUM_VEC-1, else increment the index and return to ISSUE_ENC; the index SHALL NOT wrap.
REQ-024 SHALL hold seq_done high for one cycle in DONE; busy SHALL be high in every state except IDLE.
REQ-025 SHALL ignore vec_we while busy=1; in IDLE, a write SHALL complete in one cycle.
REQ-026 SHALL ignore run while busy=1, and run together with vec_we in IDLE SHALL perform the write and start the sequence in the same cycle.

Reset
REQ-027 SHALL, on reset_n low, asynchronously force the FSM to IDLE, core_start, busy, seq_done and fail_seen to 0, counters and first_fail_idx to 0, and core_* data and core_opmode to 0.
REQ-028 SHALL, when reset is applied mid-sequence, abandon the sequence with no partial counts retained; vector table contents SHALL be undefined after reset.

Configuration
REQ-029 SHALL, with XOOD_SEQ_ROUNDTRIP_EN defined, insert ISSUE_DEC -> WAIT_DEC -> CHECK_DEC after CHECK_ENC: core_opmode=1, core_textin = captured ciphertext, pass requires recovered text == vec_pt and tag == vec_tag, and each vector counts once (pass only if both legs pass).
REQ-030 SHALL, without XOOD_SEQ_ROUNDTRIP_EN, omit the DEC states entirely and hold core_opmode at 0.

Structure
REQ-031 SHALL place the FSM state enum, the vector record typedef (key, nonce, ad, pt, ct, tag) and the 128-bit field width constant in package xood_seq_pkg.
REQ-032 SHALL use one sub-module, xood_timeout_ctr, with load, enable and expired signals, shared by the WAIT states.

Verification
REQ-033 SHALL cover: NUM_VEC=4, all vectors correct, run pulse -> pass_cnt=4, fail_cnt=0, fail_seen=0, seq_done pulse once.
REQ-034 SHALL cover: vector 2 with tag bit 0 flipped -> pass_cnt=3, fail_cnt=1, first_fail_idx=2.
REQ-035 SHALL cover: core never asserts done for vector 1, TIMEOUT_CYC=16 -> fail_cnt=1 and vector 1 declared failed at 17 cycles after core_start.
REQ-036 SHALL cover: reset_n dropped in WAIT_ENC of vector 1 -> all outputs 0 asynchronously, FSM in IDLE, and a new run restarts at vector 0.
REQ-037 SHALL cover: run during busy and vec_we during busy -> no effect on index, counts or table.
REQ-038 SHALL cover: XOOD_SEQ_ROUNDTRIP_EN with key 6162...70, nonce 3031...3f, ad 4142...50, pt 4142...58 -> core_opmode 0 then 1, pass_cnt=1.
